// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory read bus between fetch unit and memory
interface instr_fetch_if;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic [31:0] MemRData;
  logic        MemReady;

  modport master (output MemAddr, output MemRead, input MemRData, input MemReady);
  modport slave  (input MemAddr, input MemRead, output MemRData, output MemReady);
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM with wait-state timeout, flush and IR field decode
module instr_fetch #(
  parameter int          TIMEOUT_CYCLES = 15,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         IRWrite,
  input  logic         Flush,
  input  logic [31:0]  PC,
  instr_fetch_if.master mem,
  output logic [5:0]   Op,
  output logic [4:0]   Rs,
  output logic [4:0]   Rt,
  output logic [4:0]   Rd,
  output logic [4:0]   Shamt,
  output logic [5:0]   Funct,
  output logic [15:0]  Imm16,
  output logic [25:0]  Target26,
  output logic         InstrValid,
  output logic         Stall,
  output logic         BusError
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  logic [2:0]    state;
  logic [31:0]   ir;
  logic [31:0]   mem_addr;
  logic [CW-1:0] cnt;
  logic          bus_error;

  // Flush is tested before MemReady so an aborted fetch never writes IR.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      ir        <= NOP_INSTR;
      mem_addr  <= 32'h0;
      cnt       <= '0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IRWrite && !Flush) begin
            state    <= REQ;
            mem_addr <= PC;
          end
        end
        REQ: begin
          cnt <= '0;
          if (Flush) begin
            state <= IDLE;
          end else if (mem.MemReady) begin
            ir    <= mem.MemRData;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (Flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (mem.MemReady) begin
            ir    <= mem.MemRData;
            state <= DONE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            ir        <= NOP_INSTR;
            bus_error <= 1'b1;
            state     <= ERR;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.MemAddr = mem_addr;
  assign mem.MemRead = (state == REQ) || (state == WAIT);
  assign Stall       = (state == REQ) || (state == WAIT);
  assign InstrValid  = (state == DONE) || (state == ERR);
  assign BusError    = bus_error;

  assign Op       = ir[31:26];
  assign Rs       = ir[25:21];
  assign Rt       = ir[20:16];
  assign Rd       = ir[15:11];
  assign Shamt    = ir[10:6];
  assign Funct    = ir[5:0];
  assign Imm16    = ir[15:0];
  assign Target26 = ir[25:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam int          T   = 15;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IRWrite;
  logic        Flush;
  logic [31:0] PC;
  logic [5:0]  Op;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [5:0]  Funct;
  logic [15:0] Imm16;
  logic [25:0] Target26;
  logic        InstrValid, Stall, BusError;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ir;
  logic        exp_be;

  instr_fetch_if bus();

  instr_fetch #(.TIMEOUT_CYCLES(T), .NOP_INSTR(NOP)) dut (
    .Clk(Clk), .Reset(Reset), .IRWrite(IRWrite), .Flush(Flush), .PC(PC),
    .mem(bus.master),
    .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
    .Imm16(Imm16), .Target26(Target26),
    .InstrValid(InstrValid), .Stall(Stall), .BusError(BusError)
  );

  always #5 Clk = ~Clk;

  wire [31:0] obs_ir = {Op, Rs, Rt, Rd, Shamt, Funct};

  // Reference: cycle 0 is the request cycle; a ready at cycle d <= T is accepted, a flush at
  // cycle f wins if it comes no later than the ready/timeout, otherwise cycles 0..T expire.
  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data, input int d, input int f);
    bit flushed, timed;
    int last;
    flushed = (f >= 0) && (f <= d) && (f <= T);
    timed   = !flushed && (d > T);
    last    = flushed ? f : (timed ? T : d);
    PC = pc; IRWrite = 1'b1; Flush = 1'b0; bus.MemReady = 1'b0;
    @(posedge Clk); #1;
    for (int c = 0; c <= last; c++) begin
      bus.MemReady = (c == d);
      bus.MemRData = (c == d) ? data : $urandom;
      Flush        = (c == f);
      IRWrite      = 1'($urandom);
      PC           = (c == 1) ? 32'h0000_0080 : $urandom;
      @(negedge Clk);
      checks++;
      if ({Stall, bus.MemRead, InstrValid} !== 3'b110) begin
        failures++;
        $display("FAIL busy_flags cycle=%0d got=%b exp=110", c, {Stall, bus.MemRead, InstrValid});
      end
      checks++;
      if (bus.MemAddr !== pc) begin
        failures++;
        $display("FAIL memaddr_stable cycle=%0d got=%h exp=%h", c, bus.MemAddr, pc);
      end
      checks++;
      if (obs_ir !== exp_ir || BusError !== exp_be) begin
        failures++;
        $display("FAIL ir_hold cycle=%0d ir=%h be=%b exp_ir=%h exp_be=%b", c, obs_ir, BusError, exp_ir, exp_be);
      end
      @(posedge Clk); #1;
    end
    Flush = 1'b0;
    IRWrite = flushed ? 1'b0 : 1'($urandom);
    bus.MemReady = 1'($urandom);
    bus.MemRData = $urandom;
    if (!flushed) begin
      exp_ir = timed ? NOP : data;
      if (timed) exp_be = 1'b1;
    end
    @(negedge Clk);
    checks++;
    if ({Stall, bus.MemRead, InstrValid} !== {2'b00, !flushed}) begin
      failures++;
      $display("FAIL end_flags got=%b exp=%b", {Stall, bus.MemRead, InstrValid}, {2'b00, !flushed});
    end
    checks++;
    if (obs_ir !== exp_ir || Imm16 !== exp_ir[15:0] || Target26 !== exp_ir[25:0]) begin
      failures++;
      $display("FAIL ir_result got=%h imm=%h tgt=%h exp=%h", obs_ir, Imm16, Target26, exp_ir);
    end
    checks++;
    if (BusError !== exp_be) begin
      failures++;
      $display("FAIL bus_error got=%b exp=%b", BusError, exp_be);
    end
    @(posedge Clk); #1;
    if (!flushed) begin
      IRWrite = 1'b0;
      bus.MemReady = 1'($urandom);
      @(negedge Clk);
      checks++;
      if ({Stall, bus.MemRead, InstrValid} !== 3'b000 || obs_ir !== exp_ir) begin
        failures++;
        $display("FAIL after_valid flags=%b ir=%h exp_flags=000 exp_ir=%h",
                 {Stall, bus.MemRead, InstrValid}, obs_ir, exp_ir);
      end
      @(posedge Clk); #1;
    end
    IRWrite = 1'b0; bus.MemReady = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; IRWrite = 1'b0; Flush = 1'b0; PC = 32'h0;
    bus.MemReady = 1'b0; bus.MemRData = 32'h0;
    exp_ir = NOP; exp_be = 1'b0;
    #2;
    checks++;
    if ({Stall, bus.MemRead, InstrValid, BusError} !== 4'b0000 || obs_ir !== NOP || bus.MemAddr !== 32'h0) begin
      failures++;
      $display("FAIL reset_state flags=%b ir=%h addr=%h exp_flags=0000 exp_ir=%h exp_addr=0",
               {Stall, bus.MemRead, InstrValid, BusError}, obs_ir, bus.MemAddr, NOP);
    end
    @(posedge Clk); #1; Reset = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    checks++;
    if (bus.MemRead !== 1'b0) begin
      failures++;
      $display("FAIL no_fetch_after_release got=%b exp=0", bus.MemRead);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_zero_wait();
    run_fetch(32'h0000_0040, 32'h8C22_0004, 0, -1);
    checks++;
    if (Op !== 6'h23 || Rt !== 5'd2 || Imm16 !== 16'h0004) begin
      failures++;
      $display("FAIL zero_wait_fields op=%h rt=%0d imm=%h exp op=23 rt=2 imm=0004", Op, Rt, Imm16);
    end
  endtask

  task automatic test_wait_states();
    run_fetch(32'h0000_0044, 32'h0043_0820, 3, -1);
    checks++;
    if (Op !== 6'h00 || Funct !== 6'h20 || Rd !== 5'd1) begin
      failures++;
      $display("FAIL wait_fields op=%h funct=%h rd=%0d exp op=00 funct=20 rd=1", Op, Funct, Rd);
    end
  endtask

  task automatic test_timeout();
    run_fetch(32'h0000_0048, 32'hDEAD_BEEF, 40, -1);
    checks++;
    if (obs_ir !== 32'h0 || BusError !== 1'b1) begin
      failures++;
      $display("FAIL timeout_state ir=%h be=%b exp ir=00000000 be=1", obs_ir, BusError);
    end
    run_fetch(32'h0000_004C, 32'h1234_5678, 2, -1);
    checks++;
    if (BusError !== 1'b1 || obs_ir !== 32'h1234_5678) begin
      failures++;
      $display("FAIL post_timeout be=%b ir=%h exp be=1 ir=12345678", BusError, obs_ir);
    end
  endtask

  task automatic test_flush();
    run_fetch(32'h0000_0050, 32'hAAAA_5555, 4, 4);
    run_fetch(32'h0000_0054, 32'h5555_AAAA, 0, 0);
    IRWrite = 1'b1; Flush = 1'b1; PC = 32'h0000_0060;
    @(posedge Clk); #1;
    IRWrite = 1'b0; Flush = 1'b0;
    @(negedge Clk);
    checks++;
    if (bus.MemRead !== 1'b0 || Stall !== 1'b0) begin
      failures++;
      $display("FAIL idle_flush memread=%b stall=%b exp 0 0", bus.MemRead, Stall);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid_fetch();
    PC = 32'h0000_0040; IRWrite = 1'b1;
    @(posedge Clk); #1; IRWrite = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #2;
    Reset = 1'b0;
    exp_ir = NOP; exp_be = 1'b0;
    #1;
    checks++;
    if ({Stall, bus.MemRead, InstrValid, BusError} !== 4'b0000 || obs_ir !== NOP || bus.MemAddr !== 32'h0) begin
      failures++;
      $display("FAIL async_reset flags=%b ir=%h addr=%h exp_flags=0000 exp_ir=%h exp_addr=0",
               {Stall, bus.MemRead, InstrValid, BusError}, obs_ir, bus.MemAddr, NOP);
    end
    @(posedge Clk); #1; Reset = 1'b1;
    bus.MemReady = 1'b1; bus.MemRData = 32'hFFFF_FFFF;
    @(negedge Clk);
    @(posedge Clk); #1;
    @(negedge Clk);
    checks++;
    if (InstrValid !== 1'b0 || bus.MemRead !== 1'b0 || obs_ir !== NOP) begin
      failures++;
      $display("FAIL ready_after_reset valid=%b memread=%b ir=%h exp 0 0 %h", InstrValid, bus.MemRead, obs_ir, NOP);
    end
    bus.MemReady = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int d, f;
      d = ($urandom_range(0, 4) == 0) ? $urandom_range(T + 1, T + 5) : $urandom_range(0, T);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 2) : -1;
      run_fetch($urandom, $urandom, d, f);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_flush();
    test_random();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
